// File: rtl/prv_trap_types_pkg.sv
// Shared types and constants for the trap/return sequencer.
package prv_trap_types_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2,
        SLEEP    = 2'd3
    } trap_state_t;

    typedef enum logic {
        TRAP = 1'b0,
        RET  = 1'b1
    } trap_kind_t;

    // xtvec[1:0] mode field; 2 and 3 fall back to direct
    localparam logic [1:0] XTVEC_DIRECT   = 2'd0;
    localparam logic [1:0] XTVEC_VECTORED = 2'd1;

    // Common cause codes (exception codes, interrupt codes share the numbering space)
    localparam int CAUSE_MISALIGNED_FETCH = 0;
    localparam int CAUSE_FETCH_FAULT      = 1;
    localparam int CAUSE_ILLEGAL          = 2;
    localparam int CAUSE_BREAKPOINT       = 3;
    localparam int CAUSE_ECALL_M          = 11;
    localparam int CAUSE_M_SOFT           = 3;
    localparam int CAUSE_M_TIMER          = 7;
    localparam int CAUSE_M_EXT            = 11;

endpackage

// File: rtl/prv_prio_enc.sv
// Fixed-priority encoder: valid flag plus index of the winning request.
// LSB_FIRST=1 picks the lowest set bit, LSB_FIRST=0 the highest.
module prv_prio_enc #(
    parameter int N         = 16,
    parameter bit LSB_FIRST = 1'b1,
    parameter int IW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Scan so that the last hit in loop order is the highest-priority bit
    always_comb begin
        valid = |req;
        idx   = '0;
        if (LSB_FIRST) begin
            for (int i = N - 1; i >= 0; i--)
                if (req[i]) idx = IW'(i);
        end else begin
            for (int i = 0; i < N; i++)
                if (req[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/prv_trap_sequencer.sv
// Trap/return sequencer: arbitrates exceptions, xRET, interrupts and WFI,
// drains the pipeline, then issues a one-cycle redirect and CSR strobes.
module prv_trap_sequencer
    import prv_trap_types_pkg::*;
#(
    parameter int NUM_EXC = 16,
    parameter int NUM_INT = 12,
    parameter int XLEN    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_EXC-1:0] exc_vec,
    input  logic [XLEN-1:0]    exc_epc,
    input  logic [XLEN-1:0]    exc_badaddr,
    input  logic [NUM_INT-1:0] irq_enabled,
    input  logic [NUM_INT-1:0] irq_wake,
    input  logic [XLEN-1:0]    irq_epc,
    input  logic               ret,
    input  logic               wfi,
    input  logic [XLEN-1:0]    xtvec,
    input  logic [XLEN-1:0]    xepc_r,
    input  logic               pipe_clear,
    output logic               intr,
    output logic               insert_pc,
    output logic [XLEN-1:0]    priv_pc,
    output logic               csr_trap_we,
    output logic [XLEN-1:0]    cause,
    output logic [XLEN-1:0]    epc_out,
    output logic [XLEN-1:0]    tval_out,
    output logic               ret_done,
    output logic               wfi_stall
);

    localparam int EIW = (NUM_EXC > 1) ? $clog2(NUM_EXC) : 1;
    localparam int IIW = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;

    trap_state_t     state_q, state_d;
    trap_kind_t      kind_q, kind_d;
    logic [XLEN-1:0] cause_d, epc_d, tval_d, priv_pc_d, trap_target;
    logic            exc_valid, irq_valid;
    logic [EIW-1:0]  exc_idx;
    logic [IIW-1:0]  irq_idx;

    prv_prio_enc #(.N(NUM_EXC), .LSB_FIRST(1'b1), .IW(EIW)) u_exc_enc (
        .req   (exc_vec),
        .valid (exc_valid),
        .idx   (exc_idx)
    );

    prv_prio_enc #(.N(NUM_INT), .LSB_FIRST(1'b0), .IW(IIW)) u_irq_enc (
        .req   (irq_enabled),
        .valid (irq_valid),
        .idx   (irq_idx)
    );

    // Trap target: aligned base, offset by code*4 only for vectored interrupts
    always_comb begin
        trap_target = {xtvec[XLEN-1:2], 2'b00};
        if (xtvec[1:0] == XTVEC_VECTORED && cause[XLEN-1])
            trap_target = trap_target + {cause[XLEN-3:0], 2'b00};
    end

    // Next state and next values of the latched trap record / redirect target
    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        cause_d   = cause;
        epc_d     = epc_out;
        tval_d    = tval_out;
        priv_pc_d = '0;
        case (state_q)
            IDLE: begin
                if (exc_valid) begin
                    cause_d = XLEN'(exc_idx);
                    epc_d   = exc_epc;
                    tval_d  = exc_badaddr;
                    kind_d  = TRAP;
                    state_d = DRAIN;
                end else if (ret) begin
                    kind_d  = RET;
                    state_d = DRAIN;
                end else if (irq_valid) begin
                    cause_d = {1'b1, (XLEN-1)'(irq_idx)};
                    epc_d   = irq_epc;
                    tval_d  = '0;
                    kind_d  = TRAP;
                    state_d = DRAIN;
                end else if (wfi && !(|irq_wake)) begin
                    state_d = SLEEP;
                end
            end
            DRAIN: begin
                if (pipe_clear) begin
                    state_d   = REDIRECT;
                    priv_pc_d = (kind_q == RET) ? xepc_r : trap_target;
                end
            end
            REDIRECT: state_d = IDLE;
            SLEEP:    if (|irq_wake) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State, trap record and all strobes registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            kind_q      <= TRAP;
            cause       <= '0;
            epc_out     <= '0;
            tval_out    <= '0;
            priv_pc     <= '0;
            intr        <= 1'b0;
            insert_pc   <= 1'b0;
            csr_trap_we <= 1'b0;
            ret_done    <= 1'b0;
            wfi_stall   <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            cause       <= cause_d;
            epc_out     <= epc_d;
            tval_out    <= tval_d;
            priv_pc     <= priv_pc_d;
            intr        <= (state_d == DRAIN);
            insert_pc   <= (state_d == REDIRECT);
            csr_trap_we <= (state_d == REDIRECT) && (kind_d == TRAP);
            ret_done    <= (state_d == REDIRECT) && (kind_d == RET);
            wfi_stall   <= (state_d == SLEEP);
        end
    end

endmodule

// File: tb/tb_prv_trap_sequencer.sv
// Directed bench for prv_trap_sequencer with hand-computed expectations.
module tb_prv_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] exc_vec;
    logic [31:0] exc_epc, exc_badaddr, irq_epc, xtvec, xepc_r;
    logic [11:0] irq_enabled, irq_wake;
    logic        ret, wfi, pipe_clear;
    logic        intr, insert_pc, csr_trap_we, ret_done, wfi_stall;
    logic [31:0] priv_pc, cause, epc_out, tval_out;

    int checks = 0;
    int errors = 0;

    prv_trap_sequencer #(.NUM_EXC(16), .NUM_INT(12), .XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .exc_vec     (exc_vec),
        .exc_epc     (exc_epc),
        .exc_badaddr (exc_badaddr),
        .irq_enabled (irq_enabled),
        .irq_wake    (irq_wake),
        .irq_epc     (irq_epc),
        .ret         (ret),
        .wfi         (wfi),
        .xtvec       (xtvec),
        .xepc_r      (xepc_r),
        .pipe_clear  (pipe_clear),
        .intr        (intr),
        .insert_pc   (insert_pc),
        .priv_pc     (priv_pc),
        .csr_trap_we (csr_trap_we),
        .cause       (cause),
        .epc_out     (epc_out),
        .tval_out    (tval_out),
        .ret_done    (ret_done),
        .wfi_stall   (wfi_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".intr"},        32'(intr),        32'd0);
        chk({tag, ".insert_pc"},   32'(insert_pc),   32'd0);
        chk({tag, ".csr_trap_we"}, 32'(csr_trap_we), 32'd0);
        chk({tag, ".ret_done"},    32'(ret_done),    32'd0);
        chk({tag, ".wfi_stall"},   32'(wfi_stall),   32'd0);
        chk({tag, ".priv_pc"},     priv_pc,          32'd0);
        chk({tag, ".cause"},       cause,            32'd0);
        chk({tag, ".epc_out"},     epc_out,          32'd0);
        chk({tag, ".tval_out"},    tval_out,         32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        exc_vec = '0; exc_epc = '0; exc_badaddr = '0; irq_epc = '0;
        irq_enabled = '0; irq_wake = '0; ret = 1'b0; wfi = 1'b0;
        xtvec = 32'h8000_0001; xepc_r = '0; pipe_clear = 1'b0;
        tick(); tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();
        chk_all_zero("post_reset_idle");

        // 1: exception cause 2, redirect two cycles after trigger
        exc_vec = 16'h0004; exc_epc = 32'h100; exc_badaddr = 32'h55;
        tick();                                  // N -> DRAIN
        exc_vec = '0; pipe_clear = 1'b1;
        chk("t1.intr", 32'(intr), 32'd1);
        chk("t1.insert_pc_early", 32'(insert_pc), 32'd0);
        tick();                                  // N+2: REDIRECT
        pipe_clear = 1'b0;
        chk("t1.insert_pc", 32'(insert_pc), 32'd1);
        chk("t1.priv_pc", priv_pc, 32'h8000_0000);
        chk("t1.cause", cause, 32'd2);
        chk("t1.epc_out", epc_out, 32'h100);
        chk("t1.tval_out", tval_out, 32'h55);
        chk("t1.csr_trap_we", 32'(csr_trap_we), 32'd1);
        chk("t1.ret_done", 32'(ret_done), 32'd0);
        chk("t1.intr_drop", 32'(intr), 32'd0);
        tick();
        chk("t1.insert_pc_one", 32'(insert_pc), 32'd0);
        chk("t1.csr_we_one", 32'(csr_trap_we), 32'd0);
        chk("t1.cause_hold", cause, 32'd2);

        // 2: highest interrupt line wins, vectored target
        irq_enabled = 12'h088; irq_epc = 32'h200;
        tick();
        irq_enabled = '0; pipe_clear = 1'b1;
        tick();
        pipe_clear = 1'b0;
        chk("t2.cause", cause, 32'h8000_0007);
        chk("t2.priv_pc", priv_pc, 32'h8000_001C);
        chk("t2.tval_out", tval_out, 32'd0);
        chk("t2.epc_out", epc_out, 32'h200);
        chk("t2.csr_trap_we", 32'(csr_trap_we), 32'd1);
        tick();

        // 3: exception beats ret and interrupt; held ret taken afterwards
        exc_vec = 16'h0004; ret = 1'b1; irq_enabled = 12'h800; exc_epc = 32'h300;
        xepc_r = 32'h444;
        tick();
        exc_vec = '0; irq_enabled = '0; pipe_clear = 1'b1;
        tick();
        pipe_clear = 1'b0;
        chk("t3.cause", cause, 32'd2);
        chk("t3.epc_out", epc_out, 32'h300);
        chk("t3.csr_trap_we", 32'(csr_trap_we), 32'd1);
        chk("t3.ret_done_exc", 32'(ret_done), 32'd0);
        tick();                                  // back in IDLE, ret still high
        tick();                                  // ret accepted -> DRAIN
        ret = 1'b0; pipe_clear = 1'b1;
        chk("t3.ret_intr", 32'(intr), 32'd1);
        tick();
        pipe_clear = 1'b0;
        chk("t3.ret_insert_pc", 32'(insert_pc), 32'd1);
        chk("t3.ret_priv_pc", priv_pc, 32'h444);
        chk("t3.ret_done", 32'(ret_done), 32'd1);
        chk("t3.ret_csr_we", 32'(csr_trap_we), 32'd0);
        chk("t3.ret_cause_hold", cause, 32'd2);
        tick();
        chk("t3.ret_done_one", 32'(ret_done), 32'd0);

        // 4a: WFI sleep, wake without global enable -> no trap
        wfi = 1'b1;
        tick();
        wfi = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("t4.wfi_stall", 32'(wfi_stall), 32'd1);
            tick();
        end
        irq_wake = 12'h800;
        tick();
        irq_wake = '0;
        chk("t4.wake_stall", 32'(wfi_stall), 32'd0);
        tick();
        chk("t4.no_trap_intr", 32'(intr), 32'd0);
        chk("t4.no_trap_insert", 32'(insert_pc), 32'd0);

        // 4b: WFI, wake with enabled interrupt -> trap cause 11, vectored
        wfi = 1'b1;
        tick();
        wfi = 1'b0;
        chk("t4b.wfi_stall", 32'(wfi_stall), 32'd1);
        tick();
        irq_wake = 12'h800; irq_enabled = 12'h800; irq_epc = 32'h700;
        tick();                                  // SLEEP -> IDLE
        chk("t4b.wake_stall", 32'(wfi_stall), 32'd0);
        tick();                                  // IDLE takes the interrupt
        irq_wake = '0; irq_enabled = '0; pipe_clear = 1'b1;
        chk("t4b.intr", 32'(intr), 32'd1);
        tick();
        pipe_clear = 1'b0;
        chk("t4b.cause", cause, 32'h8000_000B);
        chk("t4b.priv_pc", priv_pc, 32'h8000_002C);
        chk("t4b.epc_out", epc_out, 32'h700);
        tick();

        // 5: reset while draining with pipe_clear pending aborts the sequence
        exc_vec = 16'h0002;
        tick();
        exc_vec = '0; pipe_clear = 1'b1;
        chk("t5.intr", 32'(intr), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("t5.in_reset");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5.no_insert", 32'(insert_pc), 32'd0);
            chk("t5.no_csr_we", 32'(csr_trap_we), 32'd0);
        end
        chk("t5.cause", cause, 32'd0);
        pipe_clear = 1'b0;

        // 6: long drain with exc_vec churning; latched cause must hold
        exc_vec = 16'h0020; exc_epc = 32'h600; exc_badaddr = 32'h66;
        tick();
        for (int i = 0; i < 50; i++) begin
            exc_vec = (i % 2 == 0) ? 16'h0001 : 16'h8000;
            exc_epc = 32'(i);
            tick();
            chk("t6.intr", 32'(intr), 32'd1);
            chk("t6.insert_pc", 32'(insert_pc), 32'd0);
        end
        exc_vec = '0; pipe_clear = 1'b1;
        tick();
        pipe_clear = 1'b0;
        chk("t6.insert_pc", 32'(insert_pc), 32'd1);
        chk("t6.cause", cause, 32'd5);
        chk("t6.epc_out", epc_out, 32'h600);
        chk("t6.priv_pc", priv_pc, 32'h8000_0000);
        tick();

        // 7: mode 2 treated as direct for an interrupt
        xtvec = 32'h1000_0102; irq_enabled = 12'h008;
        tick();
        irq_enabled = '0; pipe_clear = 1'b1;
        tick();
        pipe_clear = 1'b0;
        chk("t7.cause", cause, 32'h8000_0003);
        chk("t7.priv_pc", priv_pc, 32'h1000_0100);
        tick();

        // 8: vectored target wraps modulo 2^32
        xtvec = 32'hFFFF_FFFD; irq_enabled = 12'h080;
        tick();
        irq_enabled = '0; pipe_clear = 1'b1;
        tick();
        pipe_clear = 1'b0;
        chk("t8.priv_pc_wrap", priv_pc, 32'h0000_0018);
        tick();
        chk("t8.priv_pc_clear", 32'(insert_pc), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
